instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage directly upstream of `general_register`. It reads the current PC from the register file's PC port, fetches the instruction word over a valid/ready instruction-memory interface, and holds it in a one-entry buffer until decode accepts it. It then advances the PC by writing `pc + 4` (or a redirect target) back through `pc_write_data` / `pc_write_enable`.

## Interface
Parameters:
- `PC_STEP`, 4: byte increment applied to the PC after an instruction is consumed.

Ports:
- `clk`  in  1  clock; one clock domain, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_read_data`  in  32  current PC from the register file.
- `pc_write_data`  out  32  next PC to the register file.
- `pc_write_enable`  out  1  PC write strobe; the register file latches on the next rising edge.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request when valid && ready.
- `imem_addr`  out  32  fetch byte address, always word aligned.
- `imem_resp_valid`  in  1  one-cycle pulse with read data, at least 1 cycle after acceptance.
- `imem_resp_data`  in  32  instruction word.
- `inst_valid`  out  1  buffered instruction available to decode.
- `inst_ready`  in  1  decode consumes when valid && ready.
- `inst_data`  out  32  buffered instruction.
- `inst_pc`  out  32  PC of the buffered instruction.
- `redirect_valid`  in  1  branch/jump redirect pulse.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and forced to 0.

## Operation
- States: `IDLE`, `REQ`, `WAIT`, `HOLD`, `DROP`.
- Only one request is outstanding at a time.
- `IDLE` (reset state): always moves to `REQ` on the next cycle.
- `REQ`: `imem_req_valid`=1 and `imem_addr`=`{pc_read_data[31:2],2'b00}`. On acceptance, latch `inst_pc` and go to `WAIT`. The address may change while the request is not yet accepted; memory samples only on acceptance.
- `WAIT`: on `imem_resp_valid`, capture `inst_data` and go to `HOLD`.
- `HOLD`: `inst_valid`=1. On `inst_ready`, drive `pc_write_enable`=1 and `pc_write_data`=`inst_pc + PC_STEP` (mod 2^32, wraps `FFFF_FFFC`→`0`), then go to `REQ`.
- Redirect is accepted in every state except `IDLE`, and has priority over all other events:
  - Same cycle: `pc_write_enable`=1, `pc_write_data`=`{redirect_pc[31:2],2'b00}`.
  - `inst_valid` drops next cycle and the buffered instruction is discarded, even if `inst_ready` is high in the same cycle (no consume).
  - If a response is still owed (state `WAIT`, or `REQ` with acceptance in the same cycle), go to `DROP`; otherwise go to `REQ`.
- `DROP`: wait for `imem_resp_valid`, discard the data, then go to `REQ`. A further redirect while in `DROP` updates the PC and stays in `DROP`.
- A response arriving in the same cycle as a redirect in `WAIT` is discarded; go to `REQ`, not `DROP`.
- `pc_write_enable` is asserted only in the consume and redirect cases above; otherwise it is 0 and `pc_write_data` is don't-care (drive 0).

## Timing
- Reset values: `imem_req_valid`=0, `imem_addr`=0, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `pc_write_enable`=0, `pc_write_data`=0.
- Reset mid-operation aborts every state to `IDLE`; the first request after reset uses the address in `pc_read_data` (register-file reset value 0).
- `inst_valid`, `inst_data` and `inst_pc` are registered outputs. `imem_req_valid`, `imem_addr`, `pc_write_*` are combinational from state and inputs.
- Best-case throughput, zero-wait memory: REQ (cycle 0) → response (cycle 1) → `inst_valid` (cycle 2) → consume + PC write (cycle 2) → next REQ (cycle 3) with the updated PC.
- A redirect in cycle N: the request for the target is issued in cycle N+1 at the earliest (N+2+ via `DROP`).
- `inst_valid` stays high with stable `inst_data`/`inst_pc` until consumed or redirected.

## Structure
- Shared package `core_pkg` holds:
  - `typedef enum logic [2:0] fetch_state_t {IDLE, REQ, WAIT, HOLD, DROP}`.
  - `localparam XLEN = 32`.
  - `localparam logic [31:0] INST_NOP = 32'h0000_0013` (driven on `inst_data` only when invalid is not required; keep 0).
- No sub-module. The one-entry buffer and FSM are inline; about 150–250 lines.

## Test plan
- Reset, PC=0, memory returns `32'h0010_0093` one cycle after acceptance, `inst_ready`=1 → `imem_addr`=0, `inst_data`=`0010_0093`, `inst_pc`=0, `pc_write_data`=4 with a single-cycle `pc_write_enable`.
- `inst_ready` held 0 for 5 cycles in `HOLD` → `inst_valid`, `inst_data` and `inst_pc` stable, no new request, `pc_write_enable`=0.
- Redirect to `0x0000_0102` while in `WAIT` → `pc_write_data`=`0x100`; the late response is dropped (never seen on `inst_valid`); the next request has `imem_addr`=`0x100`.
- Redirect and `inst_ready` in the same `HOLD` cycle (`inst_pc`=`0x20`, target `0x80`) → `pc_write_data`=`0x80`, not `0x24`; the instruction is not counted as consumed.
- PC=`0xFFFF_FFFC`, consume → `pc_write_data`=0.
- `rst_n` asserted during `WAIT` then released, stale response pulse arrives → outputs return to reset values, stale data ignored, new request to `pc_read_data`.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: fetch FSM encoding, datapath width and address helpers.
package core_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  // Clear the byte-offset bits so fetch and PC addresses stay word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem request, one-entry instruction buffer,
// PC advance / redirect written back to the register file PC port.
module instruction_fetch
  import core_pkg::*;
#(
  parameter int unsigned PC_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_read_data,
  output logic [XLEN-1:0] pc_write_data,
  output logic            pc_write_enable,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_t    state_q, state_d;
  logic            inst_valid_q;
  logic [XLEN-1:0] inst_data_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            redirect;
  logic            accept;
  logic            consume;

  // Next state and combinational handshake / PC write-back.
  always_comb begin
    state_d         = state_q;
    imem_req_valid  = 1'b0;
    imem_addr       = '0;
    pc_write_enable = 1'b0;
    pc_write_data   = '0;

    redirect = redirect_valid && (state_q != IDLE);
    if (state_q == REQ) begin
      imem_req_valid = 1'b1;
      imem_addr      = word_align(pc_read_data);
    end
    accept  = imem_req_valid && imem_req_ready;
    consume = (state_q == HOLD) && inst_ready && !redirect;

    if (redirect) begin
      pc_write_enable = 1'b1;
      pc_write_data   = word_align(redirect_pc);
    end else if (consume) begin
      pc_write_enable = 1'b1;
      pc_write_data   = inst_pc_q + XLEN'(PC_STEP);
    end

    // A redirect must still swallow any response already owed by memory.
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (redirect)    state_d = accept ? DROP : REQ;
        else if (accept) state_d = WAIT;
      end
      WAIT: begin
        if (redirect)             state_d = imem_resp_valid ? REQ : DROP;
        else if (imem_resp_valid) state_d = HOLD;
      end
      HOLD: begin
        if (redirect || consume) state_d = REQ;
      end
      DROP: begin
        if (imem_resp_valid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // One-entry instruction buffer presented to decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
    end else begin
      if (accept) inst_pc_q <= imem_addr;
      if ((state_q == WAIT) && imem_resp_valid && !redirect) begin
        inst_data_q  <= imem_resp_data;
        inst_valid_q <= 1'b1;
      end else if (redirect || consume) begin
        inst_valid_q <= 1'b0;
      end
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst_data  = inst_data_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// traffic scored against an architectural PC model and a hashed memory image.
module tb_instruction_fetch;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_read_data, pc_write_data;
  logic        pc_write_enable;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] rf_pc;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          mem_mode;
  int          mem_lat;
  int          resp_count = 0;
  int          consumed   = 0;
  logic        sb_on;
  logic        squash_q;
  logic [31:0] model_pc;

  instruction_fetch #(.PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_read_data(pc_read_data), .pc_write_data(pc_write_data),
    .pc_write_enable(pc_write_enable),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Register-file PC: resets to 0, latches write-back on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               rf_pc <= '0;
    else if (pc_write_enable) rf_pc <= pc_write_data;
  end
  assign pc_read_data = rf_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0010_0093 ^ (a * 32'h9E37_79B9);
  endfunction

  // Memory: mode 0 never ready, 1 always ready, 2 random; latency fixed or random 1..3.
  initial begin
    logic        pend;
    logic [31:0] paddr;
    int          cnt;
    pend = 1'b0; paddr = '0; cnt = 0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    forever begin
      @(negedge clk);
      imem_resp_valid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(paddr);
          pend            = 1'b0;
          resp_count++;
        end else cnt--;
      end
      case (mem_mode)
        0:       imem_req_ready = 1'b0;
        1:       imem_req_ready = 1'b1;
        default: imem_req_ready = 1'($urandom_range(0, 1));
      endcase
      #2;
      if (imem_req_valid && imem_req_ready) begin
        pend  = 1'b1;
        paddr = imem_addr;
        cnt   = ((mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat) - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_addr"}, imem_addr, 32'd0);
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_inst_data"}, inst_data, 32'd0);
    check({tag, "_inst_pc"}, inst_pc, 32'd0);
    check({tag, "_pc_we"}, 32'(pc_write_enable), 32'd0);
    check({tag, "_pc_wdata"}, pc_write_data, 32'd0);
  endtask

  // One clock of stimulus, then architectural scoreboard on the settled outputs.
  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    #1;
    if (sb_on) begin
      if (squash_q) check("sb_squash", 32'(inst_valid), 32'd0);
      squash_q = 1'b0;
      if (imem_req_valid) check("sb_req_addr", imem_addr, model_pc);
      if (rv) begin
        check("sb_redir_we", 32'(pc_write_enable), 32'd1);
        check("sb_redir_data", pc_write_data, rpc & ~32'h3);
        model_pc = rpc & ~32'h3;
        squash_q = 1'b1;
      end else if (inst_valid && rdy) begin
        check("sb_inst_pc", inst_pc, model_pc);
        check("sb_inst_data", inst_data, mem_word(model_pc));
        check("sb_cons_we", 32'(pc_write_enable), 32'd1);
        check("sb_cons_data", pc_write_data, model_pc + 32'd4);
        model_pc = model_pc + 32'd4;
        consumed++;
      end else begin
        check("sb_quiet_we", 32'(pc_write_enable), 32'd0);
      end
    end
  endtask

  initial begin
    logic        found;
    logic [31:0] hold_data, hold_pc;
    int          c0, r0;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    mem_mode = 1; mem_lat = 1; sb_on = 1'b0; squash_q = 1'b0; model_pc = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    sb_on = 1'b1;

    // Zero-wait fetch from PC 0 and single-cycle PC write-back.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (imem_req_valid) found = 1'b1;
    end
    check("t1_req_seen", 32'(found), 32'd1);
    check("t1_addr", imem_addr, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (pc_write_enable) found = 1'b1;
    end
    check("t1_we_seen", 32'(found), 32'd1);
    check("t1_wdata", pc_write_data, 32'd4);
    check("t1_inst_data", inst_data, 32'h0010_0093);
    check("t1_inst_pc", inst_pc, 32'd0);
    cycle(1'b0, '0, 1'b0);
    check("t1_we_pulse", 32'(pc_write_enable), 32'd0);

    // Decode stalls for 5 cycles in HOLD.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b0, '0, 1'b0);
      if (inst_valid) found = 1'b1;
    end
    check("t2_valid_seen", 32'(found), 32'd1);
    check("t2_inst_pc", inst_pc, 32'd4);
    hold_data = inst_data;
    hold_pc   = inst_pc;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b0);
      check("t2_valid", 32'(inst_valid), 32'd1);
      check("t2_data", inst_data, hold_data);
      check("t2_pc", inst_pc, hold_pc);
      check("t2_no_req", 32'(imem_req_valid), 32'd0);
      check("t2_no_we", 32'(pc_write_enable), 32'd0);
    end
    cycle(1'b0, '0, 1'b1);

    // Redirect while WAIT; late response must be dropped.
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b0, '0, 1'b0);
      if (imem_req_valid) found = 1'b1;
    end
    cycle(1'b1, 32'h0000_0102, 1'b0);
    check("t3_we", 32'(pc_write_enable), 32'd1);
    check("t3_wdata", pc_write_data, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1'b0, '0, 1'b1);
      check("t3_no_stale", 32'(inst_valid), 32'd0);
      if (imem_req_valid) found = 1'b1;
    end
    check("t3_req_seen", 32'(found), 32'd1);
    check("t3_addr", imem_addr, 32'h100);
    mem_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (pc_write_enable) found = 1'b1;
    end
    check("t3_cons_pc", inst_pc, 32'h100);

    // Redirect and inst_ready together in HOLD: redirect wins.
    cycle(1'b1, 32'h20, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1'b0, '0, 1'b0);
      if (inst_valid) found = 1'b1;
    end
    check("t4_hold_pc", inst_pc, 32'h20);
    cycle(1'b1, 32'h80, 1'b1);
    check("t4_wdata", pc_write_data, 32'h80);
    cycle(1'b0, '0, 1'b0);
    check("t4_dropped", 32'(inst_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1'b0, '0, 1'b0);
      if (inst_valid) found = 1'b1;
    end
    check("t4_next_pc", inst_pc, 32'h80);
    cycle(1'b0, '0, 1'b1);

    // PC wrap at the top of the address space.
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1'b0, '0, 1'b0);
      if (inst_valid) found = 1'b1;
    end
    cycle(1'b0, '0, 1'b1);
    check("t5_we", 32'(pc_write_enable), 32'd1);
    check("t5_wrap", pc_write_data, 32'd0);

    // Reset during WAIT; the stale response must be ignored.
    cycle(1'b1, 32'h40, 1'b0);
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1'b0, '0, 1'b0);
      if (imem_req_valid) found = 1'b1;
    end
    cycle(1'b0, '0, 1'b0);
    r0 = resp_count;
    @(negedge clk);
    rst_n = 1'b0; sb_on = 1'b0; mem_mode = 0;
    redirect_valid = 1'b0; inst_ready = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1; model_pc = '0; squash_q = 1'b0; sb_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b0);
      check("t6_no_valid", 32'(inst_valid), 32'd0);
    end
    check("t6_stale_sent", 32'(resp_count > r0), 32'd1);
    check("t6_req", 32'(imem_req_valid), 32'd1);
    check("t6_addr", imem_addr, 32'd0);
    mem_mode = 1; mem_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b0, '0, 1'b0);
      if (inst_valid) found = 1'b1;
    end
    check("t6_valid_seen", 32'(found), 32'd1);
    check("t6_inst_pc", inst_pc, 32'd0);
    check("t6_inst_data", inst_data, 32'h0010_0093);
    cycle(1'b0, '0, 1'b1);

    // Random traffic: random ready, latency, decode stalls and redirects.
    mem_mode = 2; mem_lat = 0;
    c0 = consumed;
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 11) == 0), $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1);
    check("rand_progress", 32'(consumed - c0 >= 20), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
